bcd_converter: RTL
==================

# bcd_converter

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It sits between the ADC sample register and the per-digit seven-segment decoders. It converts an unsigned binary sample into DIGITS packed 4-bit BCD digits, and each digit nibble drives one decoder `din`. Results are held stable between conversions so the displays never show partial values.

## Interface
Parameters:
- `BIN_W`, default 12: width of the binary input.
- `DIGITS`, default 4: number of BCD digits produced.

Ports:
- `clk`  in  1: clock. The block uses one clock only.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: conversion request. Sampled only in IDLE.
- `bin`  in  BIN_W: unsigned value. Captured on the accepting edge.
- `busy`  out  1: high while a conversion is in progress.
- `done`  out  1: one-cycle pulse when `bcd`/`ovf` update.
- `bcd`  out  4*DIGITS: packed result. Digit 0 (ones) is in `[3:0]`; digit k is in `[4k+3:4k]`.
- `ovf`  out  1: high when the last converted value exceeded 10^DIGITS−1.

## Operation
- States are IDLE and SHIFT.
- IDLE with `start`=1:
  - Load `bin` into the shift register.
  - Clear the scratch BCD register and the overflow flag.
  - Load the bit counter with BIN_W.
  - Go to SHIFT.
- IDLE with `start`=0: hold.
- SHIFT, each cycle:
  - Add 3 to every scratch digit that is ≥5.
  - Shift {scratch, shift register} left by one.
  - Set the sticky overflow flag if the bit shifted out of the top digit is 1.
  - Decrement the counter.
- When the counter reaches 0 after the final shift:
  - Register the result into `bcd` and `ovf`.
  - Pulse `done`.
  - Return to IDLE.
- Overflow: when the sticky flag is set, `bcd` = all digits 9 (saturated) and `ovf`=1.
- `start` while `busy`=1 is ignored. There is no queueing.
- `bcd` and `ovf` change only on the `done` edge. At all other times they hold the previous result.
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `ovf`=0.
  - `bcd`=all zero.
  - Scratch registers cleared.
- Reset mid-conversion aborts the conversion. The outputs return to their reset values and no `done` pulse is produced.
- Arithmetic: each digit is 4 bits. The add-3 result of a digit ≤9 never exceeds 4 bits, so no carries pass between digits except through the shift.

## Timing
- `start` is accepted at rising edge N.
- `busy` is high from after edge N until after edge N+BIN_W.
- At edge N+BIN_W: final shift, result registered, `busy` falls, and `done` rises for exactly one cycle.
- Latency from the accepting edge to `done` high is BIN_W cycles, which is 12 at default parameters.
- A new `start` asserted in the `done` cycle is accepted. This allows back-to-back conversions every BIN_W+1 cycles.
- `bin` may change freely after the accepting edge.
- All outputs are registered. No combinational path runs from input to output.

## Configuration
- Macro `BCD_BLANK_EN` (leading-zero blanking).
- Defined:
  - Every digit above the most significant nonzero digit is replaced by 4'hF in the registered `bcd`.
  - 4'hF is a non-digit code, which the decoder renders as its default pattern.
  - Digit 0 is never blanked, so value 0 shows as a single "0".
  - When `ovf`=1, nothing is blanked.
- Not defined: all digits are output as-is, including leading zeros.
- Timing and latency are identical in both builds. Blanking is folded into the `done`-edge register.

## Test plan
- Reset, then `start` with `bin`=4095 (default parameters) → after 12 cycles `done`=1 with `bcd`=16'h4095, `ovf`=0, `busy` low in the `done` cycle.
- `bin`=1234, then `bin`=0 back-to-back, with `start` held high in the `done` cycle → `bcd`=16'h1234, then `bcd`=16'h0000 exactly 13 cycles later. Without `BCD_BLANK_EN` the second result is 16'h0000; with it, 16'hFFF0.
- `start` with `bin`=7, then pulse `start` with `bin`=99 on cycle 5 while busy → the single `done` gives 16'h0007 (16'hFFF7 with `BCD_BLANK_EN`), and no second conversion occurs.
- DIGITS=3, BIN_W=12, `bin`=1000 → `ovf`=1, `bcd`=12'h999. Then `bin`=999 → `ovf`=0, `bcd`=12'h999.
- `reset` asserted on cycle 6 of a conversion of 4095 → next cycle `busy`=0, `bcd`=0, `ovf`=0, and no `done` pulse follows.
- Exhaustive sweep of `bin` 0..4095 → each `bcd` matches a decimal reference model, and `bcd` is stable except on `done` edges.

Source files
------------

// File: rtl/bcd_converter.sv
// Purpose : sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Latency : BIN_W cycles from the accepting edge to the one-cycle done pulse.
// Backpr. : start is ignored while busy; no queueing, so the caller retries after done.
//
// Ports:
//   clk    - single clock
//   reset  - synchronous active-high reset (aborts a conversion, no done pulse)
//   start  - conversion request, sampled only in IDLE
//   bin    - unsigned binary value, captured on the accepting edge
//   busy   - high while a conversion is in progress
//   done   - one-cycle pulse when bcd/ovf update
//   bcd    - packed BCD result, digit k in [4k+3:4k], held between conversions
//   ovf    - last converted value exceeded 10^DIGITS-1 (bcd saturated to all 9s)
//
// Build option: define BCD_BLANK_EN to replace leading zero digits (above digit 0)
// by 4'hF in the registered result; never applied when ovf is set.
module bcd_converter #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [BIN_W-1:0]   sr;
  logic [BW-1:0]      scratch;
  logic               sticky;
  logic [CNT_W-1:0]   cnt;

  logic [BW-1:0]      adj;
  logic [BW-1:0]      scratch_nxt;
  logic [BIN_W-1:0]   sr_nxt;
  logic               sticky_nxt;
  logic               last;
  logic [BW-1:0]      result;
  logic               seen_nz;

  // Add-3 correction: a digit <=9 plus 3 stays within 4 bits, so digits
  // interact only through the shift below.
  always_comb begin
    adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      else                           adj[4*d +: 4] = scratch[4*d +: 4];
    end
  end

  // Shift {adj, sr} left by one; the bit leaving the top digit marks overflow.
  assign scratch_nxt = {adj[BW-2:0], sr[BIN_W-1]};
  assign sr_nxt      = {sr[BIN_W-2:0], 1'b0};
  assign sticky_nxt  = sticky | adj[BW-1];
  assign last        = (cnt == CNT_W'(1));

  // Value presented on the done edge: saturated on overflow, optionally blanked.
  always_comb begin
    result  = scratch_nxt;
    seen_nz = 1'b0;
    if (sticky_nxt) begin
      result = {DIGITS{4'h9}};
    end else begin
`ifdef BCD_BLANK_EN
      for (int k = DIGITS - 1; k >= 1; k--) begin
        if (scratch_nxt[4*k +: 4] != 4'h0) seen_nz = 1'b1;
        if (!seen_nz) result[4*k +: 4] = 4'hF;
      end
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr      <= '0;
      scratch <= '0;
      sticky  <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr      <= bin;
            scratch <= '0;
            sticky  <= 1'b0;
            cnt     <= CNT_W'(BIN_W);
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          sr      <= sr_nxt;
          scratch <= scratch_nxt;
          sticky  <= sticky_nxt;
          cnt     <= cnt - CNT_W'(1);
          if (last) begin
            bcd  <= result;
            ovf  <= sticky_nxt;
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
